// File: rtl/comp_gate.sv
// Registered magnitude comparator with saturating per-outcome event counters.
// Optional signed compare is enabled by defining COMP_GATE_SIGNED_EN.
module comp_gate #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cnt_clr,
`ifdef COMP_GATE_SIGNED_EN
  input  logic             cmp_signed,
`endif
  output logic             out_valid,
  output logic             greater,
  output logic             lesser,
  output logic             equal,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             sign_sel;
  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;

  logic             out_valid_d, out_valid_q;
  logic             greater_d, greater_q;
  logic             lesser_d, lesser_q;
  logic             equal_d, equal_q;
  logic [CNT_W-1:0] gt_cnt_d, gt_cnt_q;
  logic [CNT_W-1:0] lt_cnt_d, lt_cnt_q;
  logic [CNT_W-1:0] eq_cnt_d, eq_cnt_q;

`ifdef COMP_GATE_SIGNED_EN
  assign sign_sel = cmp_signed;
`else
  assign sign_sel = 1'b0;
`endif

  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign a_cmp  = a ^ (sign_sel ? MSB_MASK : '0);
  assign b_cmp  = b ^ (sign_sel ? MSB_MASK : '0);
  assign a_gt_b = (a_cmp > b_cmp);
  assign a_lt_b = (a_cmp < b_cmp);
  assign a_eq_b = (a_cmp == b_cmp);

  function automatic logic [CNT_W-1:0] next_cnt(
    input logic [CNT_W-1:0] cur,
    input logic             hit,
    input logic             clr,
    input logic             valid
  );
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr) begin
      nxt = '0;
    end else if (valid && hit && (cur != CNT_MAX)) begin
      nxt = cur + CNT_W'(1);
    end
    return nxt;
  endfunction

  always_comb begin
    out_valid_d = in_valid;
    greater_d   = greater_q;
    lesser_d    = lesser_q;
    equal_d     = equal_q;
    if (in_valid) begin
      greater_d = a_gt_b;
      lesser_d  = a_lt_b;
      equal_d   = a_eq_b;
    end
    gt_cnt_d = next_cnt(gt_cnt_q, a_gt_b, cnt_clr, in_valid);
    lt_cnt_d = next_cnt(lt_cnt_q, a_lt_b, cnt_clr, in_valid);
    eq_cnt_d = next_cnt(eq_cnt_q, a_eq_b, cnt_clr, in_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      greater_q   <= 1'b0;
      lesser_q    <= 1'b0;
      equal_q     <= 1'b0;
      gt_cnt_q    <= '0;
      lt_cnt_q    <= '0;
      eq_cnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      greater_q   <= greater_d;
      lesser_q    <= lesser_d;
      equal_q     <= equal_d;
      gt_cnt_q    <= gt_cnt_d;
      lt_cnt_q    <= lt_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign greater   = greater_q;
  assign lesser    = lesser_q;
  assign equal     = equal_q;
  assign gt_cnt    = gt_cnt_q;
  assign lt_cnt    = lt_cnt_q;
  assign eq_cnt    = eq_cnt_q;

endmodule

// File: tb/tb_comp_gate.sv
// Directed self-checking bench for comp_gate: a default instance plus a
// narrow-counter instance (CNT_W=2) sharing the same stimulus.
module tb_comp_gate;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [1:0]  opA;
  logic [1:0]  opB;
  logic        cntClr;
  logic        cmpSigned;

  logic        outValid, greater, lesser, equal;
  logic [15:0] gtCnt, ltCnt, eqCnt;

  logic        satOutValid, satGreater, satLesser, satEqual;
  logic [1:0]  satGtCnt, satLtCnt, satEqCnt;

  int errors;
  int checks;

  comp_gate #(.WIDTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .a         (opA),
    .b         (opB),
    .cnt_clr   (cntClr),
`ifdef COMP_GATE_SIGNED_EN
    .cmp_signed(cmpSigned),
`endif
    .out_valid (outValid),
    .greater   (greater),
    .lesser    (lesser),
    .equal     (equal),
    .gt_cnt    (gtCnt),
    .lt_cnt    (ltCnt),
    .eq_cnt    (eqCnt)
  );

  comp_gate #(.WIDTH(2), .CNT_W(2)) satDut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .a         (opA),
    .b         (opB),
    .cnt_clr   (cntClr),
`ifdef COMP_GATE_SIGNED_EN
    .cmp_signed(cmpSigned),
`endif
    .out_valid (satOutValid),
    .greater   (satGreater),
    .lesser    (satLesser),
    .equal     (satEqual),
    .gt_cnt    (satGtCnt),
    .lt_cnt    (satLtCnt),
    .eq_cnt    (satEqCnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, then waits until just
  // after the next rising edge so outputs can be sampled.
  task automatic applyStimulus(input logic valid, input logic [1:0] aVal,
                               input logic [1:0] bVal, input logic clr,
                               input logic sgn);
    @(negedge clk);
    inValid   = valid;
    opA       = aVal;
    opB       = bVal;
    cntClr    = clr;
    cmpSigned = sgn;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] flagsOf(input int x, input int y);
    return {x > y, x < y, x == y};
  endfunction

  initial begin
    logic [2:0] expFlags;
    int         expGt, expLt, expEq;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    inValid   = 1'b0;
    opA       = 2'b00;
    opB       = 2'b00;
    cntClr    = 1'b0;
    cmpSigned = 1'b0;

    // Reset state.
    #12;
    checkOutput("reset_out_valid", {31'b0, outValid}, 0);
    checkOutput("reset_flags", {29'b0, greater, lesser, equal}, 0);
    checkOutput("reset_counts", {gtCnt, ltCnt[7:0], eqCnt[7:0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_out_valid", {31'b0, outValid}, 0);

    // Saturation on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
      checkOutput($sformatf("sat_eq_cnt_%0d", i), {30'b0, satEqCnt},
                  (i < 3) ? i + 1 : 3);
    end
    checkOutput("sat_wide_eq_cnt", {16'b0, eqCnt}, 5);
    checkOutput("sat_flags", {29'b0, satGreater, satLesser, satEqual}, 3'b001);

    // Clear-only cycle resets all counters without a sample.
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    checkOutput("clr_only_out_valid", {31'b0, outValid}, 0);
    checkOutput("clr_only_eq_cnt", {16'b0, eqCnt}, 0);
    checkOutput("clr_only_sat_eq_cnt", {30'b0, satEqCnt}, 0);
    cntClr = 1'b0;

    // Exhaustive 2-bit sweep, back to back.
    expGt = 0; expLt = 0; expEq = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 2'(i >> 2), 2'(i & 3), 1'b0, 1'b0);
      expFlags = flagsOf(i >> 2, i & 3);
      if (expFlags[2]) expGt++;
      if (expFlags[1]) expLt++;
      if (expFlags[0]) expEq++;
      checkOutput($sformatf("sweep_valid_%0d", i), {31'b0, outValid}, 1);
      checkOutput($sformatf("sweep_flags_a%0d_b%0d", i >> 2, i & 3),
                  {29'b0, greater, lesser, equal}, {29'b0, expFlags});
      checkOutput($sformatf("sweep_gt_cnt_%0d", i), {16'b0, gtCnt}, expGt);
    end
    checkOutput("sweep_gt_cnt", {16'b0, gtCnt}, 6);
    checkOutput("sweep_lt_cnt", {16'b0, ltCnt}, 6);
    checkOutput("sweep_eq_cnt", {16'b0, eqCnt}, 4);

    // Hold: one lesser sample, then three idle cycles.
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b0, 1'b0);
    checkOutput("hold_sample_flags", {29'b0, greater, lesser, equal}, 3'b010);
    checkOutput("hold_sample_lt_cnt", {16'b0, ltCnt}, 7);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd3, 2'd0, 1'b0, 1'b0);
      checkOutput($sformatf("hold_out_valid_%0d", i), {31'b0, outValid}, 0);
      checkOutput($sformatf("hold_flags_%0d", i),
                  {29'b0, greater, lesser, equal}, 3'b010);
      checkOutput($sformatf("hold_counts_%0d", i),
                  {8'b0, gtCnt[7:0], ltCnt[7:0], eqCnt[7:0]}, {8'd0, 8'd6, 8'd7, 8'd4});
    end

    // Clear colliding with a sample: clear wins, flags still update.
    applyStimulus(1'b1, 2'd2, 2'd1, 1'b1, 1'b0);
    checkOutput("collide_out_valid", {31'b0, outValid}, 1);
    checkOutput("collide_flags", {29'b0, greater, lesser, equal}, 3'b100);
    checkOutput("collide_gt_cnt", {16'b0, gtCnt}, 0);
    checkOutput("collide_lt_cnt", {16'b0, ltCnt}, 0);
    checkOutput("collide_eq_cnt", {16'b0, eqCnt}, 0);
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    checkOutput("after_collide_eq_cnt", {16'b0, eqCnt}, 1);
    checkOutput("after_collide_gt_cnt", {16'b0, gtCnt}, 0);

    // Asynchronous reset mid-stream with a sample in flight.
    applyStimulus(1'b1, 2'd3, 2'd0, 1'b0, 1'b0);
    checkOutput("pre_reset_flags", {29'b0, greater, lesser, equal}, 3'b100);
    @(negedge clk);
    opA = 2'd0;
    opB = 2'd3;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_out_valid", {31'b0, outValid}, 0);
    checkOutput("async_reset_flags", {29'b0, greater, lesser, equal}, 0);
    checkOutput("async_reset_counts",
                {8'b0, gtCnt[7:0], ltCnt[7:0], eqCnt[7:0]}, 0);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_idle_out_valid", {31'b0, outValid}, 0);
    checkOutput("post_reset_idle_flags", {29'b0, greater, lesser, equal}, 0);
    applyStimulus(1'b1, 2'd1, 2'd3, 1'b0, 1'b0);
    checkOutput("post_reset_sample_valid", {31'b0, outValid}, 1);
    checkOutput("post_reset_sample_lt_cnt", {16'b0, ltCnt}, 1);

`ifdef COMP_GATE_SIGNED_EN
    // Signed vs unsigned view of a=-1, b=+1.
    applyStimulus(1'b1, 2'b11, 2'b01, 1'b0, 1'b1);
    checkOutput("signed_flags", {29'b0, greater, lesser, equal}, 3'b010);
    applyStimulus(1'b1, 2'b11, 2'b01, 1'b0, 1'b0);
    checkOutput("unsigned_flags", {29'b0, greater, lesser, equal}, 3'b100);
`endif

    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comp_gate.md
Name: comp_gate

Overview:
- Registered magnitude comparator: compares two WIDTH-bit operands a and b and reports exactly one of greater, lesser or equal.
- Keeps saturating event counters per outcome for status and debug.
- Sits in the datapath as a small pipelined compare stage with a valid qualifier.
- Default WIDTH=2 gives the classic 2-bit comparator.

Parameters:
- WIDTH, 2, operand width in bits (legal range 1..32).
- CNT_W, 16, width of each outcome event counter (legal range 1..32).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  a/b are sampled on this cycle.
- a  in  WIDTH  operand A, unsigned unless the optional feature selects signed.
- b  in  WIDTH  operand B.
- cnt_clr  in  1  synchronous clear of all three counters.
- out_valid  out  1  result registers updated from a sample this cycle.
- greater  out  1  registered A > B.
- lesser  out  1  registered A < B.
- equal  out  1  registered A == B.
- gt_cnt  out  CNT_W  number of accepted samples with A > B.
- lt_cnt  out  CNT_W  number of accepted samples with A < B.
- eq_cnt  out  CNT_W  number of accepted samples with A == B.

Behaviour:
- Reset (rst=1, asynchronous assert): out_valid, greater, lesser, equal = 0; all counters = 0.
- Deassertion takes effect at the next clk edge.
- Reset asserted mid-operation discards any in-flight result.
- Latency: 1 cycle. A sample with in_valid=1 at edge N produces results and out_valid=1 after edge N.
- out_valid=1 for exactly one cycle per accepted sample.
- Back-to-back samples are accepted every cycle; there is no backpressure.
- in_valid=0: out_valid goes 0; greater/lesser/equal hold their last values.
- Encoding: after any accepted sample, exactly one of greater/lesser/equal is 1 (one-hot). After reset and before the first sample, all three are 0.
- Default compare is unsigned over all WIDTH bits, e.g. a=2'b11, b=2'b00 gives greater=1.
- Counters:
  - On an accepted sample, the matching counter increments by 1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr=1 zeroes all counters at the edge.
  - If cnt_clr and in_valid=1 occur together, clear wins: the counters read 0 after the edge, and the sample still updates greater/lesser/equal/out_valid.
- Counter outputs are registered and reflect the sample in the same cycle that out_valid asserts.
- No X propagation from unused state; all registers are reset.

Optional Feature:
- Macro COMP_GATE_SIGNED_EN.
- When defined:
  - Extra input port cmp_signed (1 bit), sampled with in_valid.
  - cmp_signed=1 treats a and b as two's complement, e.g. WIDTH=2, a=2'b11 (-1), b=2'b01 (+1) gives lesser=1.
  - cmp_signed=0 gives the unsigned compare.
- When undefined: no cmp_signed port; the compare is always unsigned.
- Counters and the handshake are identical in both builds.

Test Plan:
- Exhaustive WIDTH=2: all 16 (a,b) pairs with in_valid=1 every cycle. Each result one cycle later matches the unsigned compare, e.g. (00,01) gives lesser; (10,10) gives equal; (11,10) gives greater. Final counts: gt_cnt=6, lt_cnt=6, eq_cnt=4.
- Reset: assert rst asynchronously mid-stream after a=3, b=0. Outputs and counters go to 0 immediately, without waiting for a clk edge; out_valid stays 0 until the next accepted sample.
- Hold: after sample a=1, b=2 (lesser=1), drive in_valid=0 for 3 cycles. out_valid=0; lesser stays 1; counters unchanged.
- Saturation: CNT_W=2, apply 5 samples with a=b=0. eq_cnt reads 1, 2, 3, 3, 3.
- Clear collision: cnt_clr=1 together with sample a=2, b=1. Counters are 0 and greater=1 with out_valid=1 after the edge.
- COMP_GATE_SIGNED_EN build with a=2'b11, b=2'b01: cmp_signed=1 gives lesser=1; cmp_signed=0 gives greater=1.
